// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared enums and playfield defaults for the pong datapath
`timescale 1ns/1ps
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    LATCH = 2'd1,
    MOVE  = 2'd2,
    DONE  = 2'd3
  } frame_state_t;

  localparam int SCREEN_W_DEF   = 640;
  localparam int PADDLE_LEN_DEF = 80;
  localparam int STEP_DEF       = 8;
  localparam int POS_W_DEF      = 10;

endpackage

// File: rtl/paddle_step.sv
// rtl/paddle_step.sv - combinational clamped paddle move for one player
`timescale 1ns/1ps
module paddle_step #(
  parameter int POS_W = 10,
  parameter int STEP  = 8,
  parameter int XMAX  = 560
) (
  input  logic [POS_W-1:0] x,
  input  logic             l,
  input  logic             r,
  output logic [POS_W-1:0] x_next
);

  localparam logic signed [POS_W:0] STEP_S = (POS_W+1)'(STEP);
  localparam logic signed [POS_W:0] XMAX_S = (POS_W+1)'(XMAX);

  // One extra signed bit so x-STEP and x+STEP never wrap before clamping
  logic signed [POS_W:0] xs, dec, inc;

  always_comb begin
    xs     = signed'({1'b0, x});
    dec    = xs - STEP_S;
    inc    = xs + STEP_S;
    x_next = x;
    if (l && !r)
      x_next = (dec < 0) ? '0 : dec[POS_W-1:0];
    else if (r && !l)
      x_next = (inc > XMAX_S) ? XMAX_S[POS_W-1:0] : inc[POS_W-1:0];
  end

endmodule

// File: rtl/paddle_input_sequencer.sv
// rtl/paddle_input_sequencer.sv - per-frame key consumer driving run mode and paddle positions
`timescale 1ns/1ps
module paddle_input_sequencer
  import pong_pkg::*;
#(
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int PADDLE_LEN = PADDLE_LEN_DEF,
  parameter int STEP       = STEP_DEF,
  parameter int POS_W      = POS_W_DEF
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             round_over,
  input  logic             isPressEnter,
  input  logic             isp1L,
  input  logic             isp1R,
  input  logic             isp2L,
  input  logic             isp2R,
  output logic             clr_keys,
  output logic             game_run,
  output logic [POS_W-1:0] p1_x,
  output logic [POS_W-1:0] p2_x,
  output logic             pos_valid,
  output logic             tick_overrun
);

  localparam int                XMAX   = SCREEN_W - PADDLE_LEN;
  localparam logic [POS_W-1:0]  CENTRE = POS_W'((SCREEN_W - PADDLE_LEN) / 2);

  frame_state_t     state, state_next;
  mode_t            mode, mode_next;
  logic [POS_W-1:0] p1_next, p2_next, p1_step, p2_step;
  logic             k_enter, k_p1l, k_p1r, k_p2l, k_p2r;

  paddle_step #(.POS_W(POS_W), .STEP(STEP), .XMAX(XMAX)) u_step_p1 (
    .x(p1_x), .l(k_p1l), .r(k_p1r), .x_next(p1_step)
  );

  paddle_step #(.POS_W(POS_W), .STEP(STEP), .XMAX(XMAX)) u_step_p2 (
    .x(p2_x), .l(k_p2l), .r(k_p2r), .x_next(p2_step)
  );

  always_ff @(posedge Clock) begin
    if (reset) begin
      state        <= WAIT;
      mode         <= IDLE;
      p1_x         <= CENTRE;
      p2_x         <= CENTRE;
      tick_overrun <= 1'b0;
      {k_enter, k_p1l, k_p1r, k_p2l, k_p2r} <= '0;
    end else begin
      state <= state_next;
      mode  <= mode_next;
      p1_x  <= p1_next;
      p2_x  <= p2_next;
      if (frame_tick && state != WAIT)
        tick_overrun <= 1'b1;
      if (state == LATCH)
        {k_enter, k_p1l, k_p1r, k_p2l, k_p2r} <= {isPressEnter, isp1L, isp1R, isp2L, isp2R};
    end
  end

  always_comb begin
    state_next = state;
    clr_keys   = 1'b0;
    pos_valid  = 1'b0;
    case (state)
      WAIT:  if (frame_tick) state_next = LATCH;
      LATCH: begin
        clr_keys   = 1'b1;
        state_next = MOVE;
      end
      MOVE:  state_next = DONE;
      DONE: begin
        pos_valid  = 1'b1;
        state_next = WAIT;
      end
      default: state_next = WAIT;
    endcase
  end

  // Movement is gated on the mode held before this frame's Enter is applied
  always_comb begin
    mode_next = mode;
    p1_next   = p1_x;
    p2_next   = p2_x;
    if (round_over) begin
      mode_next = IDLE;
      p1_next   = CENTRE;
      p2_next   = CENTRE;
    end else if (state == MOVE) begin
      if (mode == RUN) begin
        p1_next = p1_step;
        p2_next = p2_step;
      end
      if (k_enter) begin
        case (mode)
          IDLE: begin
            mode_next = RUN;
            p1_next   = CENTRE;
            p2_next   = CENTRE;
          end
          RUN:     mode_next = PAUSE;
          PAUSE:   mode_next = RUN;
          default: mode_next = IDLE;
        endcase
      end
    end
  end

  assign game_run = (mode == RUN);

endmodule

// File: tb/tb_paddle_input_sequencer.sv
// tb/tb_paddle_input_sequencer.sv - scoreboard bench with random frames and a reference model
`timescale 1ns/1ps
module tb_paddle_input_sequencer;

  logic       Clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0, round_over = 1'b0;
  logic       isPressEnter = 1'b0, isp1L = 1'b0, isp1R = 1'b0, isp2L = 1'b0, isp2R = 1'b0;
  logic       clr_keys, game_run, pos_valid, tick_overrun;
  logic [9:0] p1_x, p2_x;

  paddle_input_sequencer dut (
    .Clock(Clock), .reset(reset), .frame_tick(frame_tick), .round_over(round_over),
    .isPressEnter(isPressEnter), .isp1L(isp1L), .isp1R(isp1R), .isp2L(isp2L), .isp2R(isp2R),
    .clr_keys(clr_keys), .game_run(game_run), .p1_x(p1_x), .p2_x(p2_x),
    .pos_valid(pos_valid), .tick_overrun(tick_overrun)
  );

  always #5 Clock = ~Clock;

  typedef struct { int p1; int p2; int run; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int m_mode, m_p1, m_p2;  // 0 idle, 1 run, 2 pause

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int step_pos(input int x, input bit l, input bit r);
    if (l && !r) return (x - 8 < 0) ? 0 : x - 8;
    if (r && !l) return (x + 8 > 560) ? 560 : x + 8;
    return x;
  endfunction

  task automatic model_frame(input bit e, l1, r1, l2, r2, ro);
    exp_t ex;
    if (ro) begin
      m_mode = 0; m_p1 = 280; m_p2 = 280;
    end else begin
      if (m_mode == 1) begin
        m_p1 = step_pos(m_p1, l1, r1);
        m_p2 = step_pos(m_p2, l2, r2);
      end
      if (e) begin
        if (m_mode == 0) begin m_mode = 1; m_p1 = 280; m_p2 = 280; end
        else m_mode = (m_mode == 1) ? 2 : 1;
      end
    end
    ex.p1 = m_p1; ex.p2 = m_p2; ex.run = (m_mode == 1) ? 1 : 0;
    exp_q.push_back(ex);
  endtask

  always @(negedge Clock) begin
    if (!reset && pos_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_pos_valid: got pos_valid=1 expected no pending frame at %0t", $time);
      end else begin
        exp_t ex;
        ex = exp_q.pop_front();
        check("p1_x", int'(p1_x), ex.p1);
        check("p2_x", int'(p2_x), ex.p2);
        check("game_run", int'(game_run), ex.run);
      end
    end
  end

  task automatic do_reset();
    @(negedge Clock);
    reset = 1'b1; frame_tick = 1'b0; round_over = 1'b0;
    {isPressEnter, isp1L, isp1R, isp2L, isp2R} = '0;
    @(negedge Clock);
    check("rst_clr_keys", int'(clr_keys), 0);
    check("rst_pos_valid", int'(pos_valid), 0);
    check("rst_game_run", int'(game_run), 0);
    check("rst_tick_overrun", int'(tick_overrun), 0);
    check("rst_p1_x", int'(p1_x), 280);
    check("rst_p2_x", int'(p2_x), 280);
    reset = 1'b0;
    exp_q.delete();
    m_mode = 0; m_p1 = 280; m_p2 = 280;
  endtask

  // kind: 0 normal, 1 round_over during MOVE, 2 extra tick during LATCH, 3 reset during MOVE
  task automatic frame(input bit e, l1, r1, l2, r2, input int kind);
    @(negedge Clock);
    {isPressEnter, isp1L, isp1R, isp2L, isp2R} = {e, l1, r1, l2, r2};
    frame_tick = 1'b1;
    if (kind != 3) model_frame(e, l1, r1, l2, r2, kind == 1);
    @(negedge Clock);
    frame_tick = (kind == 2);
    check("clr_keys_t1", int'(clr_keys), 1);
    check("pos_valid_t1", int'(pos_valid), 0);
    @(negedge Clock);
    frame_tick = 1'b0;
    {isPressEnter, isp1L, isp1R, isp2L, isp2R} = '0;
    check("clr_keys_t2", int'(clr_keys), 0);
    if (kind == 2) check("tick_overrun_set", int'(tick_overrun), 1);
    round_over = (kind == 1);
    reset = (kind == 3);
    @(negedge Clock);
    round_over = 1'b0;
    if (kind == 3) begin
      check("mid_rst_pos_valid", int'(pos_valid), 0);
      check("mid_rst_clr_keys", int'(clr_keys), 0);
      check("mid_rst_game_run", int'(game_run), 0);
      check("mid_rst_tick_overrun", int'(tick_overrun), 0);
      check("mid_rst_p1_x", int'(p1_x), 280);
      check("mid_rst_p2_x", int'(p2_x), 280);
      reset = 1'b0;
      exp_q.delete();
      m_mode = 0; m_p1 = 280; m_p2 = 280;
    end else begin
      check("pos_valid_t3", int'(pos_valid), 1);
    end
    @(negedge Clock);
    check("pos_valid_t4", int'(pos_valid), 0);
    check("clr_keys_idle", int'(clr_keys), 0);
  endtask

  initial begin
    m_mode = 0; m_p1 = 280; m_p2 = 280;
    do_reset();
    frame(0, 0, 0, 0, 0, 0);
    frame(1, 0, 0, 0, 0, 0);
    frame(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 36; i++) frame(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 36; i++) frame(0, 0, 1, 0, 0, 0);
    frame(0, 1, 1, 0, 0, 0);
    frame(1, 0, 0, 0, 0, 0);
    frame(0, 0, 0, 0, 1, 0);
    frame(1, 0, 0, 0, 0, 0);
    frame(0, 0, 1, 0, 0, 1);
    check("overrun_before", int'(tick_overrun), 0);
    frame(0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 250; i++) begin
      frame(($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 15) == 0) ? 1 : 0);
    end
    check("overrun_sticky", int'(tick_overrun), 1);
    frame(0, 0, 1, 0, 0, 3);
    for (int i = 0; i < 20; i++) begin
      frame(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), 0);
    end
    repeat (3) @(negedge Clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paddle_input_sequencer.md
Name: paddle_input_sequencer

Overview:
Per-frame controller that consumes the sticky key flags produced by KBDController. It owns their clear strobe (drives rfromGameLoop) and turns the sampled flags into game run/pause state and two clamped paddle positions. It sits between the keyboard decoder and the game loop / renderer. Key state is consumed exactly once per frame_tick.

Parameters:
SCREEN_W, 640, playfield width in pixels
PADDLE_LEN, 80, paddle length in pixels
STEP, 8, pixels moved per frame per pressed direction
POS_W, 10, width of position outputs

Ports:
Clock  in  1  system clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per video frame
round_over  in  1  one-cycle pulse from ball logic; ends the round
isPressEnter  in  1  sticky Enter flag from KBDController
isp1L  in  1  sticky P1 left flag
isp1R  in  1  sticky P1 right flag
isp2L  in  1  sticky P2 left flag
isp2R  in  1  sticky P2 right flag
clr_keys  out  1  one-cycle clear pulse, wired to KBDController rfromGameLoop
game_run  out  1  high while paddles and ball are live
p1_x  out  POS_W  P1 paddle left edge
p2_x  out  POS_W  P2 paddle left edge
pos_valid  out  1  one-cycle pulse when p1_x/p2_x have been updated for this frame
tick_overrun  out  1  sticky; a frame_tick arrived while not in WAIT

Behaviour:
- Reset clock and reset: Clock; reset is synchronous and active-high.
- Reset values: clr_keys=0, game_run=0, pos_valid=0, tick_overrun=0, p1_x=p2_x=CENTRE, mode=IDLE, fsm=WAIT.
- CENTRE is (SCREEN_W-PADDLE_LEN)/2, i.e. 280 at defaults. XMAX is SCREEN_W-PADDLE_LEN, i.e. 560.
- Mode register: IDLE, RUN, PAUSE. game_run=1 only in RUN.
- Frame FSM states: WAIT, LATCH, MOVE, DONE.
  - WAIT: on frame_tick, go to LATCH.
  - LATCH: capture all five flags into internal regs; drive clr_keys=1 for exactly this cycle; go to MOVE.
  - MOVE: apply the mode and position update (rules below); go to DONE.
  - DONE: drive pos_valid=1 for one cycle; go to WAIT.
- Latency: tick seen in cycle t -> clr_keys in t+1 -> positions registered at end of t+2 -> pos_valid and new positions visible in t+3.
- Mode update in MOVE, using latched Enter:
  - IDLE+Enter -> RUN, and load p1_x=p2_x=CENTRE.
  - RUN+Enter -> PAUSE.
  - PAUSE+Enter -> RUN.
  - Otherwise the mode holds.
- Position update in MOVE: only when mode is RUN before this frame's Enter is applied. No movement in the frame that enters RUN, and none while IDLE or PAUSE.
- Per player:
  - L only: x = max(x-STEP, 0).
  - R only: x = min(x+STEP, XMAX).
  - L and R both set, or neither: x holds.
- Arithmetic is done at POS_W+1 bits signed. Neither underflow nor overflow may wrap.
- round_over: takes effect the next cycle in any FSM state. It sets mode=IDLE and loads both positions to CENTRE. FSM sequencing continues.
  - If round_over coincides with the MOVE cycle, round_over wins over any Enter or move in that cycle.
- frame_tick outside WAIT: the tick is ignored and tick_overrun is set to 1. Only reset clears tick_overrun.
- A key flag set in the same cycle as clr_keys is lost, because the clear wins in KBDController. This is accepted and must not hang the FSM.
- reset mid-sequence: all state returns to reset values within one cycle. clr_keys must not be asserted in the cycle after reset.

Decomposition:
- Shared package pong_pkg holds:
  - mode enum: IDLE=0, RUN=1, PAUSE=2;
  - frame FSM enum;
  - SCREEN_W/PADDLE_LEN defaults.
- One natural sub-module: paddle_step. It is combinational, takes x, L, R and produces the clamped next x. It is instantiated once per player.

Test Plan:
- Reset, then frame_tick with no flags -> clr_keys pulses at t+1, pos_valid at t+3, p1_x=p2_x=280, game_run=0.
- Enter set, tick -> game_run=1 at t+3, positions stay 280. Next tick with isp1R=1 -> p1_x=288, p2_x=280.
- RUN with p2_x=0 (after 35 frames of isp2L) and isp2L again -> p2_x stays 0. p1 driven right until p1_x=560, one more isp1R -> stays 560.
- RUN, isp1L=isp1R=1 -> p1_x unchanged. Enter -> PAUSE, game_run=0. isp2R while paused -> p2_x unchanged. Enter again -> game_run=1.
- round_over pulsed in the same cycle as MOVE while isp1R latched -> mode IDLE, p1_x=p2_x=280, game_run=0.
- frame_tick in LATCH -> tick_overrun=1 and no extra clr_keys. Reset asserted during MOVE -> next cycle all outputs at reset values, tick_overrun=0.
